// File: rtl/sparc_ifu_par_pkg.sv
// Default geometry for the IFU parity pipe: data width, bits per parity bit, error counter width.
package sparc_ifu_par_pkg;
  localparam int DATA_W_DEF   = 64;
  localparam int CHUNK_W_DEF  = 16;
  localparam int ERRCNT_W_DEF = 8;
endpackage

// File: rtl/sparc_ifu_par_chunk.sv
// Parity of one data chunk, optionally inverted for odd parity. Purely combinational.
module sparc_ifu_par_chunk #(
  parameter int CHUNK_W = 16
) (
  input  logic [CHUNK_W-1:0] data,
  input  logic               odd_sel,
  output logic               par
);
  assign par = (^data) ^ odd_sel;
endmodule

// File: rtl/sparc_ifu_par_pipe.sv
// Two-stage per-chunk parity generate/check with a saturating error counter.
// Latency 2 cycles, 1 word/cycle; out_* hold while out_rdy is low, in_rdy drops when both stages are full.
module sparc_ifu_par_pipe
  import sparc_ifu_par_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHUNK_W  = CHUNK_W_DEF,
  parameter int ERRCNT_W = ERRCNT_W_DEF,
  localparam int NCHUNK  = (CHUNK_W > 0) ? DATA_W / CHUNK_W : 1
) (
  input  logic                rclk,
  input  logic                arst_l,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [NCHUNK-1:0]   in_par,
  input  logic                mode_chk,
  input  logic                odd_sel,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [NCHUNK-1:0]   out_par,
  output logic [NCHUNK-1:0]   out_err,
  output logic                out_err_any,
  input  logic                err_cnt_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  if (CHUNK_W < 1 || (DATA_W % CHUNK_W) != 0) begin : g_bad_geometry
    $error("sparc_ifu_par_pipe: DATA_W must be a non-zero multiple of CHUNK_W");
  end

  logic [NCHUNK-1:0] p_comb;
  logic              s1_vld;
  logic [NCHUNK-1:0] s1_par;
  logic [NCHUNK-1:0] s1_in_par;
  logic              s1_chk;
  logic              s2_load;
  logic              s1_load;
  logic              accept;
  logic [NCHUNK-1:0] err_nxt;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
    sparc_ifu_par_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
      .data    (in_data[i*CHUNK_W +: CHUNK_W]),
      .odd_sel (odd_sel),
      .par     (p_comb[i])
    );
  end

  // Stage 2 refills whenever its current result is gone or being taken; stage 1 follows it.
  assign s2_load = !out_vld || out_rdy;
  assign s1_load = !s1_vld || s2_load;
  assign in_rdy  = s1_load;
  assign accept  = in_vld && in_rdy;

  always_comb begin
    err_nxt = '0;
    if (s1_chk) err_nxt = s1_par ^ s1_in_par;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s1_vld    <= 1'b0;
      s1_par    <= '0;
      s1_in_par <= '0;
      s1_chk    <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= in_vld;
      if (accept) begin
        s1_par    <= p_comb;
        s1_in_par <= in_par;
        s1_chk    <= mode_chk;
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      out_vld     <= 1'b0;
      out_par     <= '0;
      out_err     <= '0;
      out_err_any <= 1'b0;
    end else if (s2_load) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_par     <= s1_par;
        out_err     <= err_nxt;
        out_err_any <= |err_nxt;
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (out_vld && out_rdy && out_err_any && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
